// File: rtl/sieve_host.sv
// sieve_host: working RAM for the prime sieve plus a post-run scanner that
// streams every nonzero (prime) cell index in [START, LIMIT] over valid/ready.
module sieve_host #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int START = 2,
  parameter int LIMIT = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_wr,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_dout,
  input  logic          in_rdy,
  input  logic          in_done,
  output logic [DW-1:0] out_din,
  output logic          out_valid,
  input  logic          in_ready,
  output logic [AW-1:0] out_prime,
  output logic [AW-1:0] out_count,
  output logic          out_seen_rdy,
  output logic          out_finished
);

  typedef enum logic [2:0] {IDLE, RD, CHK, EMIT, FIN} state_t;

  // Pointer is one bit wider than the address so the LIMIT compare never
  // depends on wrap-around.
  localparam logic [AW:0] PTR_START = (AW+1)'(START);
  localparam logic [AW:0] PTR_LIMIT = (AW+1)'(LIMIT);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  state_t        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [DW-1:0] din_q;
  logic [DW-1:0] scan_data_q;
  logic          valid_q, valid_d;
  logic [AW-1:0] prime_q, prime_d;
  logic [AW-1:0] count_q, count_d;
  logic          seen_q;
  logic          finished_q, finished_d;
  logic          at_limit;

  assign at_limit = (ptr_q == PTR_LIMIT);

  // Port A write: the sieve keeps writing even while held in reset, so the
  // write is deliberately independent of rst and of the scanner state.
  always_ff @(posedge clk) begin
    if (in_wr) mem[in_addr] <= in_dout;
  end

  // Port A read: registered, read-first (same-cycle write returns old data).
  always_ff @(posedge clk) begin
    if (rst) din_q <= '0;
    else     din_q <= mem[in_addr];
  end

  // Port B read: scanner data, valid in CHK after the pointer settled in RD.
  always_ff @(posedge clk) begin
    scan_data_q <= mem[ptr_q[AW-1:0]];
  end

  // Scanner state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_START;
      valid_q    <= 1'b0;
      prime_q    <= '0;
      count_q    <= '0;
      seen_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      prime_q    <= prime_d;
      count_q    <= count_d;
      seen_q     <= seen_q | in_rdy;
      finished_q <= finished_d;
    end
  end

  // Scanner next-state logic: RD/CHK per cell, EMIT holds until accepted.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    prime_d    = prime_q;
    count_d    = count_q;
    finished_d = finished_q;
    case (state_q)
      IDLE: begin
        if (in_done) begin
          ptr_d   = PTR_START;
          state_d = RD;
        end
      end
      RD: begin
        state_d = CHK;
      end
      CHK: begin
        if (scan_data_q != '0) begin
          prime_d = ptr_q[AW-1:0];
          valid_d = 1'b1;
          state_d = EMIT;
        end else if (at_limit) begin
          finished_d = 1'b1;
          state_d    = FIN;
        end else begin
          ptr_d   = ptr_q + (AW+1)'(1);
          state_d = RD;
        end
      end
      EMIT: begin
        if (in_ready) begin
          valid_d = 1'b0;
          count_d = count_q + AW'(1);
          if (at_limit) begin
            finished_d = 1'b1;
            state_d    = FIN;
          end else begin
            ptr_d   = ptr_q + (AW+1)'(1);
            state_d = RD;
          end
        end
      end
      FIN: begin
        finished_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_din      = din_q;
  assign out_valid    = valid_q;
  assign out_prime    = prime_q;
  assign out_count    = count_q;
  assign out_seen_rdy = seen_q;
  assign out_finished = finished_q;

endmodule

// File: tb/tb_sieve_host.sv
// tb_sieve_host: table-driven port A checks plus scoreboarded scan runs
// (full prime stream, backpressure, LIMIT boundary, empty scan, mid-scan reset).
module tb_sieve_host;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int START = 2;
  localparam int LIMIT = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dout = '0;
  logic          rdy = 1'b0;
  logic          done = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] din;
  logic          valid;
  logic [AW-1:0] prime;
  logic [AW-1:0] count;
  logic          seen_rdy;
  logic          finished;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sieve_host #(.AW(AW), .DW(DW), .START(START), .LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .in_wr(wr),
    .in_addr(addr),
    .in_dout(dout),
    .in_rdy(rdy),
    .in_done(done),
    .out_din(din),
    .out_valid(valid),
    .in_ready(ready),
    .out_prime(prime),
    .out_count(count),
    .out_seen_rdy(seen_rdy),
    .out_finished(finished)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: primes; mode 1: all zero; mode 2: primes plus forced 100 and 101
  function automatic logic [DW-1:0] cell_val(input int mode, input int a);
    if (mode == 1) return '0;
    if (mode == 2 && (a == 100 || a == 101)) return 8'h01;
    return is_prime(a) ? (8'(a) | 8'h80) : 8'h00;
  endfunction

  function automatic int push_expected(input int mode);
    int n = 0;
    for (int a = START; a <= LIMIT; a++) begin
      if (cell_val(mode, a) != 0) begin
        exp_q.push_back(a);
        n++;
      end
    end
    return n;
  endfunction

  // Stream monitor: every accepted beat must match the scoreboard head, and
  // a beat not accepted must be held unchanged in the next cycle.
  logic          prev_valid = 1'b0;
  logic          prev_acc = 1'b0;
  logic [AW-1:0] prev_prime = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_valid && !prev_acc) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_prime", 32'(prime), 32'(prev_prime));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_prime: got %0d expected no beat", prime);
        end else begin
          check("stream_prime", 32'(prime), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = valid;
      prev_prime = prime;
      prev_acc = valid && ready;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"}, 32'(din), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_prime"}, 32'(prime), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_seen"}, 32'(seen_rdy), 32'd0);
    check({tag, "_finished"}, 32'(finished), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    done = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_ram(input int mode, input bit pulse_rdy, output int n);
    for (int a = 0; a < (1 << AW); a++) begin
      wr = 1'b1;
      addr = AW'(a);
      dout = cell_val(mode, a);
      rdy = pulse_rdy && (a == 10);
      @(posedge clk); #1;
    end
    wr = 1'b0;
    rdy = 1'b0;
    n = push_expected(mode);
  endtask

  // Start a scan; optionally hold ready low for 5 cycles on prime hold_at.
  task automatic run_scan(input int hold_at, input int exp_count);
    int cycles = 0;
    bit held = 1'b0;
    logic [AW-1:0] cnt0;
    ready = 1'b1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    while (!finished && cycles < 2000) begin
      if (hold_at >= 0 && !held && valid && prime == AW'(hold_at)) begin
        held = 1'b1;
        ready = 1'b0;
        cnt0 = count;
        repeat (5) begin
          @(negedge clk);
          check("bp_prime", 32'(prime), 32'(hold_at));
          check("bp_count", 32'(count), 32'(cnt0));
          @(posedge clk); #1;
        end
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_count_release", 32'(count), 32'(cnt0) + 1);
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("scan_in_budget", 32'(cycles < 2000), 32'd1);
    if (hold_at >= 0) check("bp_seen_prime", 32'(held), 32'd1);
    check("scan_finished", 32'(finished), 32'd1);
    check("scan_count", 32'(count), 32'(exp_count));
    check("scan_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int cycles;

    vecs[0] = '{1'b1, 8'd7, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'd7, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 8'd7, 8'h11, 1'b1, 8'hA5};
    vecs[3] = '{1'b0, 8'd7, 8'h00, 1'b1, 8'h11};
    vecs[4] = '{1'b1, 8'd8, 8'h3C, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'd8, 8'h00, 1'b1, 8'h3C};
    vecs[6] = '{1'b0, 8'd7, 8'h00, 1'b1, 8'h11};

    @(posedge clk); #1;
    do_reset();

    // Port A readback table
    for (int i = 0; i < 7; i++) begin
      wr = vecs[i].wr;
      addr = vecs[i].addr;
      dout = vecs[i].dout;
      @(posedge clk); #1;
      if (vecs[i].chk) check($sformatf("porta_vec%0d", i), 32'(din), 32'(vecs[i].exp));
    end
    wr = 1'b0;

    // Full run with backpressure on prime 2
    load_ram(0, 1'b1, n);
    check("seen_rdy_sticky", 32'(seen_rdy), 32'd1);
    run_scan(2, n);
    check("full_count_25", 32'(count), 32'd25);
    check("full_seen_rdy", 32'(seen_rdy), 32'd1);
    done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    done = 1'b0;
    check("fin_ignores_done_valid", 32'(valid), 32'd0);
    check("fin_ignores_done_count", 32'(count), 32'd25);
    check("fin_stays", 32'(finished), 32'd1);

    // Boundary: 100 emitted, 101 never
    do_reset();
    load_ram(2, 1'b0, n);
    run_scan(-1, n);
    check("boundary_count_26", 32'(count), 32'd26);

    // Empty scan timing
    do_reset();
    load_ram(1, 1'b0, n);
    ready = 1'b1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    repeat (197) @(posedge clk);
    #1;
    check("empty_not_yet_finished", 32'(finished), 32'd0);
    @(posedge clk); #1;
    check("empty_finished_on_time", 32'(finished), 32'd1);
    check("empty_count", 32'(count), 32'd0);

    // Reset mid-scan while emitting 11, then rescan
    do_reset();
    load_ram(0, 1'b0, n);
    ready = 1'b1;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    cycles = 0;
    while (!(valid && prime == 8'd11) && cycles < 500) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("reached_prime_11", 32'(valid && prime == 8'd11), 32'd1);
    ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midscan_reset");
    rst = 1'b0;
    exp_q.delete();
    n = push_expected(0);
    run_scan(-1, n);
    check("rescan_count_25", 32'(count), 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
